fifo_wr_ctrl: RTL and testbench



---
 rtl/fifo_wr_ctrl.sv | 103 ++++++++++
 tb/tb_fifo_wr_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Async FIFO write-side controller: write pointer, Gray pointer,
// read-pointer synchroniser, full/almost-full/level flags, sticky overflow.
module fifo_wr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  winc,
    input  logic                  clr_ovf,
    input  logic [ADDR_WIDTH:0]   gray_rd_ptr,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  w_en,
    output logic [ADDR_WIDTH:0]   gray_wr_ptr,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    if (ADDR_WIDTH < 2) begin : g_bad_aw
        $error("fifo_wr_ctrl: ADDR_WIDTH must be >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > (1 << ADDR_WIDTH)) begin : g_bad_af
        $error("fifo_wr_ctrl: AFULL_THRESH out of range");
    end
    if (SYNC_STAGES < 2) begin : g_bad_ss
        $error("fifo_wr_ctrl: SYNC_STAGES must be >= 2");
    end

    localparam logic [ADDR_WIDTH:0] AFULL = AFULL_THRESH[ADDR_WIDTH:0];

    function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        b[ADDR_WIDTH] = g[ADDR_WIDTH];
        for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] wr_ptr_next;
    logic [ADDR_WIDTH:0] gray_next;
    logic [ADDR_WIDTH:0] rq;
    logic [ADDR_WIDTH:0] rq_full;
    logic [ADDR_WIDTH:0] level_next;
    logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
    logic                ovf_evt;

    assign rq = sync_q[SYNC_STAGES-1];

    // Memory must not be written while reset is being applied.
    assign w_en        = winc & ~wfull & wrst_n;
    assign w_addr      = wr_ptr[ADDR_WIDTH-1:0];
    assign wr_ptr_next = wr_ptr + {{ADDR_WIDTH{1'b0}}, w_en};
    assign gray_next   = bin2gray(wr_ptr_next);
    assign rq_full     = {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]};
    assign level_next  = wr_ptr_next - gray2bin(rq);
    assign ovf_evt     = winc & wfull;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= gray_rd_ptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wr_ptr       <= '0;
            gray_wr_ptr  <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            gray_wr_ptr  <= gray_next;
            wfull        <= (gray_next == rq_full);
            walmost_full <= (level_next >= AFULL);
            wlevel       <= level_next;
            // Set has priority over clear so a coincident overflow is not lost.
            if (ovf_evt) begin
                woverflow <= 1'b1;
            end else if (clr_ovf) begin
                woverflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl (defaults: depth 8, afull 6, 2 sync stages).
// Table of fill/overflow vectors plus hand sequences for the multi-cycle cases.
module tb_fifo_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       winc;
    logic       clr_ovf;
    logic [3:0] gray_rd_ptr;
    logic [2:0] w_addr;
    logic       w_en;
    logic [3:0] gray_wr_ptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wlevel;
    logic       woverflow;

    int npass = 0;
    int ntot  = 0;

    fifo_wr_ctrl #(
        .ADDR_WIDTH  (3),
        .AFULL_THRESH(6),
        .SYNC_STAGES (2)
    ) dut (
        .wclk        (wclk),
        .wrst_n      (wrst_n),
        .winc        (winc),
        .clr_ovf     (clr_ovf),
        .gray_rd_ptr (gray_rd_ptr),
        .w_addr      (w_addr),
        .w_en        (w_en),
        .gray_wr_ptr (gray_wr_ptr),
        .wfull       (wfull),
        .walmost_full(walmost_full),
        .wlevel      (wlevel),
        .woverflow   (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic       clr;
        logic [3:0] grd;
        logic       en;
        logic [2:0] addr;
        logic [3:0] gw;
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [3:0] g_of(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [3:0] gw,
                            input logic full, input logic af,
                            input logic [3:0] lvl, input logic ovf);
        chk({tag, ".gray_wr_ptr"}, int'(gray_wr_ptr), int'(gw));
        chk({tag, ".wfull"}, int'(wfull), int'(full));
        chk({tag, ".walmost_full"}, int'(walmost_full), int'(af));
        chk({tag, ".wlevel"}, int'(wlevel), int'(lvl));
        chk({tag, ".woverflow"}, int'(woverflow), int'(ovf));
    endtask

    logic [3:0] gseq[8];
    logic [3:0] pm;
    logic [3:0] prev_gray;
    logic [2:0] prev_addr;
    logic       saw_gwrap;
    logic       saw_awrap;

    initial begin
        gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                 4'b0111, 4'b0101, 4'b0100, 4'b1100};
        for (int i = 0; i < 8; i++) begin
            tbl[i].winc = 1'b1;
            tbl[i].clr  = 1'b0;
            tbl[i].grd  = 4'b0000;
            tbl[i].en   = 1'b1;
            tbl[i].addr = 3'(i);
            tbl[i].gw   = gseq[i];
            tbl[i].full = (i == 7);
            tbl[i].af   = (i >= 5);
            tbl[i].lvl  = 4'(i + 1);
            tbl[i].ovf  = 1'b0;
        end
        // overflow, clear, overflow+clear together, clear
        tbl[8]  = '{1'b1, 1'b0, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 4'b0000, 1'b0, 3'd0, 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0};

        // reset held two edges with winc high
        wrst_n = 1'b0; winc = 1'b1; clr_ovf = 1'b0; gray_rd_ptr = 4'b0000;
        #1;
        chk("rst0.w_en", int'(w_en), 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst.w_en", int'(w_en), 0);
            chk_regs("rst", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        chk("rst.w_addr", int'(w_addr), 0);
        wrst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            winc = tbl[i].winc; clr_ovf = tbl[i].clr; gray_rd_ptr = tbl[i].grd;
            #1;
            chk($sformatf("v%0d.w_en", i), int'(w_en), int'(tbl[i].en));
            chk($sformatf("v%0d.w_addr", i), int'(w_addr), int'(tbl[i].addr));
            tick();
            chk_regs($sformatf("v%0d", i), tbl[i].gw, tbl[i].full, tbl[i].af,
                     tbl[i].lvl, tbl[i].ovf);
        end

        // drain visibility: read pointer 4 appears after three edges
        winc = 1'b0; clr_ovf = 1'b0; gray_rd_ptr = 4'b0110;
        tick(); chk_regs("drain1", 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0);
        tick(); chk_regs("drain2", 4'b1100, 1'b1, 1'b1, 4'd8, 1'b0);
        tick(); chk_regs("drain3", 4'b1100, 1'b0, 1'b0, 4'd4, 1'b0);

        // empty out, then wrap with the reader following the writer
        gray_rd_ptr = 4'b1100;
        tick(); tick(); tick();
        chk_regs("empty", 4'b1100, 1'b0, 1'b0, 4'd0, 1'b0);
        pm = 4'd8; saw_gwrap = 1'b0; saw_awrap = 1'b0; prev_addr = 3'd0;
        for (int k = 0; k < 20; k++) begin
            winc = 1'b1; gray_rd_ptr = g_of(pm);
            #1;
            chk("wrap.w_addr", int'(w_addr), int'(pm[2:0]));
            chk("wrap.w_en", int'(w_en), 1);
            if (k > 0 && prev_addr == 3'd7 && w_addr == 3'd0) saw_awrap = 1'b1;
            prev_addr = w_addr;
            prev_gray = gray_wr_ptr;
            tick();
            pm = pm + 4'd1;
            chk("wrap.gray", int'(gray_wr_ptr), int'(g_of(pm)));
            chk("wrap.wlevel", int'(wlevel), (k < 2) ? k + 1 : 3);
            chk("wrap.wfull", int'(wfull), 0);
            if (prev_gray == 4'b1000 && gray_wr_ptr == 4'b0000) saw_gwrap = 1'b1;
        end
        chk("wrap.gray_1000_0000", int'(saw_gwrap), 1);
        chk("wrap.addr_7_0", int'(saw_awrap), 1);

        // refill to full, overflow, then partial drain to level 5
        winc = 1'b0; gray_rd_ptr = g_of(4'd12);
        tick(); tick(); tick();
        chk("pre.wlevel", int'(wlevel), 0);
        winc = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk_regs("refill", g_of(4'd4), 1'b1, 1'b1, 4'd8, 1'b0);
        tick();
        chk_regs("ovf2", g_of(4'd4), 1'b1, 1'b1, 4'd8, 1'b1);
        winc = 1'b0; gray_rd_ptr = g_of(4'd15);
        tick(); tick(); tick();
        chk_regs("lvl5", g_of(4'd4), 1'b0, 1'b0, 4'd5, 1'b1);

        // reset mid-operation
        wrst_n = 1'b0; gray_rd_ptr = 4'b0000;
        #1;
        chk("mrst.w_en", int'(w_en), 0);
        tick();
        chk_regs("mrst", 4'b0000, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("mrst.w_addr", int'(w_addr), 0);
        wrst_n = 1'b1; winc = 1'b1;
        #1;
        chk("post.w_addr", int'(w_addr), 0);
        chk("post.w_en", int'(w_en), 1);
        tick();
        chk_regs("post", 4'b0001, 1'b0, 1'b0, 4'd1, 1'b0);
        winc = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
